// File: rtl/sme_match_queue.sv
// Match-vector queue: a small FIFO feeding a hold register that presents
// one non-zero rule ID at a time, lowest slot first, until each is released.
module sme_match_queue #(
    parameter int ADDR_WIDTH = 2,
    parameter int SLOTS      = 8,
    parameter int ID_WIDTH   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic [SLOTS*ID_WIDTH-1:0] in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      match_release,
    output logic [ID_WIDTH-1:0]       match_rule_ID,
    output logic                      match_valid,
    output logic [SLOTS-1:0]          match_valid_stat
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int VW    = SLOTS * ID_WIDTH;

    logic [VW-1:0]         mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  dout_valid;
    logic [VW-1:0]         dout_data;
    logic                  push, pop;

    logic [VW-1:0]         hold_data;
    logic [SLOTS-1:0]      hold_v, mask, pending;
    logic [SLOTS-1:0]      slot_nz;
    logic [SLOTS-1:0]      sel, sel_r;
    logic [ID_WIDTH-1:0]   sel_id;

    assign dout_valid = (count != '0);
    assign dout_data  = mem[rd_ptr];
    assign in_ready   = (count != (ADDR_WIDTH+1)'(DEPTH));
    assign pending    = hold_v & mask;
    assign push       = in_valid && in_ready && !clear;
    assign pop        = dout_valid && (pending == '0) && !clear;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        slot_nz = '0;
        for (int unsigned k = 0; k < SLOTS; k++)
            slot_nz[k] = |dout_data[k*ID_WIDTH +: ID_WIDTH];
    end

    // hold_data is also flushed so the presented ID reads 0 after clear
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            hold_data <= '0;
            hold_v    <= '0;
            mask      <= '1;
        end else if (pop) begin
            hold_data <= dout_data;
            hold_v    <= slot_nz;
            mask      <= '1;
        end else if (match_release) begin
            mask <= mask & ~sel_r;
        end
    end

    always_comb begin
        logic found;
        sel    = '0;
        sel_id = hold_data[ID_WIDTH-1:0];
        found  = 1'b0;
        for (int unsigned k = 0; k < SLOTS; k++) begin
            if (pending[k] && !found) begin
                sel[k] = 1'b1;
                sel_id = hold_data[k*ID_WIDTH +: ID_WIDTH];
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_r            <= '0;
            match_rule_ID    <= '0;
            match_valid      <= 1'b0;
            match_valid_stat <= '0;
        end else begin
            sel_r            <= sel;
            match_rule_ID    <= sel_id;
            match_valid      <= |pending;
            match_valid_stat <= pending;
        end
    end

endmodule

// File: tb/tb_sme_match_queue.sv
// Self-checking bench for sme_match_queue: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_sme_match_queue;

    localparam int AW    = 2;
    localparam int SL    = 8;
    localparam int IW    = 16;
    localparam int DEPTH = 1 << AW;
    localparam int VW    = SL * IW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic [VW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          match_release = 1'b0;
    logic [IW-1:0] match_rule_ID;
    logic          match_valid;
    logic [SL-1:0] match_valid_stat;

    int nvec = 0;
    int nerr = 0;

    sme_match_queue #(.ADDR_WIDTH(AW), .SLOTS(SL), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .match_release(match_release), .match_rule_ID(match_rule_ID),
        .match_valid(match_valid), .match_valid_stat(match_valid_stat)
    );

    always #5 clk = ~clk;

    // Reference model: queued vectors plus the set of still-pending slots
    logic [VW-1:0] mq[$];
    logic [VW-1:0] mhold = '0;
    logic [SL-1:0] mpend = '0;
    logic [SL-1:0] msel_r = '0;
    logic [IW-1:0] e_id = '0;
    logic          e_valid = 1'b0;
    logic [SL-1:0] e_stat = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [VW-1:0] vec1(input int s, input logic [IW-1:0] id);
        logic [VW-1:0] v;
        v = '0;
        v[s*IW +: IW] = id;
        return v;
    endfunction

    task automatic model_edge();
        int lo;
        logic [SL-1:0] nsel;
        bit was_full;
        logic [VW-1:0] h;
        if (rst) begin
            mq.delete();
            mhold = '0; mpend = '0; msel_r = '0;
            e_id = '0; e_valid = 1'b0; e_stat = '0;
            return;
        end
        lo = -1;
        for (int i = 0; i < SL; i++)
            if (mpend[i] && lo < 0) lo = i;
        nsel    = (lo >= 0) ? SL'(1) << lo : '0;
        e_id    = (lo >= 0) ? mhold[lo*IW +: IW] : mhold[IW-1:0];
        e_valid = (mpend != 0);
        e_stat  = mpend;
        if (clear) begin
            mq.delete();
            mhold = '0;
            mpend = '0;
        end else begin
            was_full = (mq.size() == DEPTH);
            if (mq.size() > 0 && mpend == 0) begin
                h = mq.pop_front();
                mhold = h;
                for (int i = 0; i < SL; i++)
                    mpend[i] = (h[i*IW +: IW] != 0);
            end else if (match_release) begin
                mpend = mpend & ~msel_r;
            end
            if (in_valid && !was_full)
                mq.push_back(in_data);
        end
        msel_r = nsel;
    endtask

    task automatic step(input logic v, input logic [VW-1:0] d, input logic rel,
                        input logic clr, input logic rs);
        in_valid = v; in_data = d; match_release = rel; clear = clr; rst = rs;
        @(posedge clk);
        model_edge();
        #1;
        chk("valid", 32'(match_valid), 32'(e_valid));
        chk("id", 32'(match_rule_ID), 32'(e_id));
        chk("stat", 32'(match_valid_stat), 32'(e_stat));
        chk("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [VW-1:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rel();
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic [VW-1:0] rv;
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_valid", 32'(match_valid), 32'd0);

        // single vector: slot2=5, slot6=9
        push(vec1(2, 16'h0005) | vec1(6, 16'h0009));
        idle(); idle();
        chk("sv_id0", 32'(match_rule_ID), 32'h5);
        chk("sv_stat0", 32'(match_valid_stat), 32'h44);
        rel(); idle();
        chk("sv_id1", 32'(match_rule_ID), 32'h9);
        chk("sv_stat1", 32'(match_valid_stat), 32'h40);
        rel(); idle();
        chk("sv_valid2", 32'(match_valid), 32'd0);
        chk("sv_stat2", 32'(match_valid_stat), 32'h0);

        // back-to-back
        push(vec1(0, 16'h0011));
        push(vec1(7, 16'h0022));
        idle();
        chk("bb_a", 32'(match_rule_ID), 32'h11);
        rel(); idle(); idle();
        chk("bb_b", 32'(match_rule_ID), 32'h22);
        chk("bb_stat", 32'(match_valid_stat), 32'h80);
        rel(); idle(); idle();

        // overflow: A held, 4 queued, 5th dropped
        push(vec1(1, 16'h0040));
        idle(); idle();
        for (int j = 0; j < 5; j++) begin
            push(vec1(j % SL, 16'(16'h0050 + j)));
            if (j == 3) chk("ovf_full", 32'(in_ready), 32'd0);
        end
        for (int j = 0; j < 6; j++) begin
            rel(); idle(); idle();
        end
        chk("ovf_drain", 32'(match_valid), 32'd0);

        // clear with 2 queued and one presented
        push(vec1(4, 16'h0aaa));
        push(vec1(5, 16'h0bbb));
        push(vec1(6, 16'h0ccc));
        idle();
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("clr_ready", 32'(in_ready), 32'd1);
        idle();
        chk("clr_valid", 32'(match_valid), 32'd0);
        rel(); idle();
        chk("clr_rel", 32'(match_valid), 32'd0);

        // zero vector skipped
        push('0);
        push(vec1(3, 16'h0100));
        idle(); idle();
        chk("zero_id", 32'(match_rule_ID), 32'h100);
        chk("zero_stat", 32'(match_valid_stat), 32'h08);

        // reset mid-stream
        push(vec1(0, 16'h0777));
        push(vec1(1, 16'h0888));
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("mrst_valid", 32'(match_valid), 32'd0);
        chk("mrst_id", 32'(match_rule_ID), 32'd0);
        chk("mrst_ready", 32'(in_ready), 32'd1);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            rv = '0;
            if ($urandom_range(7) != 0)
                for (int s = 0; s < SL; s++)
                    if ($urandom_range(2) == 0)
                        rv[s*IW +: IW] = 16'($urandom_range(16'hffff, 1));
            step($urandom_range(2) == 0, rv, $urandom_range(2) == 0,
                 $urandom_range(99) == 0, $urandom_range(299) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
